// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the dot-product accumulator.
// Optional saturation is selected in mult_dot_acc by MULT_DOT_ACC_SATURATE_EN.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int PROD_W_DEF = 8;

    // Widest sum of len products of prod_w bits fits in prod_w + clog2(len) bits.
    function automatic int acc_w_def(input int prod_w, input int len);
        return prod_w + $clog2(len);
    endfunction

endpackage

// File: rtl/acc_add.sv
// ACC_W-bit unsigned parallel-prefix adder with carry-out (Kogge-Stone,
// grey cells where the lower group already reaches bit 0, black cells elsewhere).
module acc_add #(
    parameter int W = 10
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    always_comb begin : p_prefix
        logic [W-1:0] w_p0;
        logic [W-1:0] w_g;
        logic [W-1:0] w_p;
        logic [W-1:0] w_g_n;
        logic [W-1:0] w_p_n;

        o_sum  = '0;
        o_cout = 1'b0;
        w_p0   = i_a ^ i_b;
        w_g    = i_a & i_b;
        w_p    = w_p0;
        w_g_n  = w_g;
        w_p_n  = w_p;
        for (int d = 1; d < W; d = d * 2) begin
            w_g_n = w_g;
            w_p_n = w_p;
            for (int i = 0; i < W; i++) begin
                if (i >= 2 * d) begin
                    w_g_n[i] = w_g[i] | (w_p[i] & w_g[i-d]);
                    w_p_n[i] = w_p[i] & w_p[i-d];
                end else if (i >= d) begin
                    w_g_n[i] = w_g[i] | (w_p[i] & w_g[i-d]);
                end
            end
            w_g = w_g_n;
            w_p = w_p_n;
        end
        // After the prefix tree w_g[i] is the carry out of bit i.
        o_sum[0] = w_p0[0];
        for (int i = 1; i < W; i++) begin
            o_sum[i] = w_p0[i] ^ w_g[i-1];
        end
        o_cout = w_g[W-1];
    end

endmodule

// File: rtl/mult_dot_acc.sv
// Accumulates LEN unsigned products into one dot-product result behind a valid/ready port.
// Define MULT_DOT_ACC_SATURATE_EN to clamp on carry-out instead of wrapping.
//
// state | meaning
// IDLE  | waiting for the first beat of a new sum
// ACCUM | partial sum in progress, accepting beats
// HOLD  | result presented, input stalled until drained
module mult_dot_acc
    import mult_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int LEN    = 4,
    parameter int ACC_W  = acc_w_def(PROD_W, LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [PROD_W-1:0] prod,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res,
    output logic              res_ovf
);

    localparam int CNT_W = $clog2(LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic [ACC_W-1:0]   r_res;
    logic               r_res_ovf;
    logic [ACC_W-1:0]   w_prod_ext;
    logic [ACC_W-1:0]   w_sum;
    logic               w_cout;
    logic [ACC_W-1:0]   w_acc_upd;
    logic               w_ovf_upd;

    assign w_prod_ext = ACC_W'(prod);

    acc_add #(.W(ACC_W)) u_acc_add (
        .i_a    (r_acc),
        .i_b    (w_prod_ext),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

`ifdef MULT_DOT_ACC_SATURATE_EN
    // Once clamped, any further non-zero beat carries out again, so it stays clamped.
    assign w_acc_upd = w_cout ? {ACC_W{1'b1}} : w_sum;
`else
    assign w_acc_upd = w_sum;
`endif
    assign w_ovf_upd = r_ovf | w_cout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (!flush && prod_valid) begin
                    w_state_next = (LEN == 1) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (flush) begin
                    w_state_next = IDLE;
                end else if (prod_valid && (r_cnt == CNT_LAST)) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        prod_ready = 1'b0;
        res_valid  = 1'b0;
        case (r_state)
            IDLE:    prod_ready = 1'b1;
            ACCUM:   prod_ready = 1'b1;
            HOLD:    res_valid  = 1'b1;
            default: prod_ready = 1'b0;
        endcase
    end

    // The result register is loaded on the final beat so it is valid the cycle HOLD begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_res     <= '0;
            r_res_ovf <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (flush) begin
                        r_acc <= '0;
                        r_cnt <= '0;
                    end else if (prod_valid) begin
                        r_acc <= w_prod_ext;
                        r_cnt <= CNT_W'(1);
                        r_ovf <= 1'b0;
                        if (LEN == 1) begin
                            r_res     <= w_prod_ext;
                            r_res_ovf <= 1'b0;
                        end
                    end
                end
                ACCUM: begin
                    if (flush) begin
                        r_acc <= '0;
                        r_cnt <= '0;
                    end else if (prod_valid) begin
                        r_acc <= w_acc_upd;
                        r_cnt <= r_cnt + CNT_W'(1);
                        r_ovf <= w_ovf_upd;
                        if (r_cnt == CNT_LAST) begin
                            r_res     <= w_acc_upd;
                            r_res_ovf <= w_ovf_upd;
                        end
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        r_cnt <= '0;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign res     = r_res;
    assign res_ovf = r_res_ovf;

endmodule
